// File: rtl/full_adder_pkg.sv
// Shared constants for the bit-serial full adder: default word width and
// the step-index width derived from it.
package full_adder_pkg;

  localparam int WIDTH_DEF = 6;

  // A one-step word still needs a 1-bit index register.
  function automatic int idx_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int IDX_W = idx_w(WIDTH_DEF);

  function automatic logic majority(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Purely combinational 1-bit full add, the arithmetic core of each serial step.
module fa_cell
  import full_adder_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = majority(x, y, ci);

endmodule

// File: rtl/full_adder.sv
// Bit-serial adder: a parallel word A plus a serial stream B, one bit per
// clock, LSB first, with registered sum and carry outputs.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic             b,
  input  logic             cin,
  output logic             sum,
  output logic             cout
);

  localparam int             IW   = idx_w(WIDTH);
  localparam logic [IW-1:0]  LAST = IW'(WIDTH - 1);

  logic [IW-1:0] idx;
  logic          carry_q;
  logic          a_bit;
  logic          ci;
  logic          s;
  logic          c;

  // Word carry-in only enters at step 0, so no carry leaks across words.
  always_comb begin
    a_bit = a[idx];
    ci    = (idx == '0) ? cin : carry_q;
  end

  fa_cell u_cell (
    .x  (a_bit),
    .y  (b),
    .ci (ci),
    .s  (s),
    .co (c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (idx == LAST) begin
      idx <= '0;
    end else begin
      idx <= idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum     <= 1'b0;
      cout    <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      sum     <= s;
      cout    <= c;
      carry_q <= c;
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder against a word-level arithmetic model.
module tb_full_adder;

  localparam int W = 6;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic         b;
  logic         cin;
  logic         sum;
  logic         cout;

  int total;
  int bad;

  // Operand bits actually presented in the current word, assembled per step.
  int a_acc;
  int b_acc;
  int c0_acc;

  full_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic exp_sum, input logic exp_cout);
    total++;
    assert (sum === exp_sum) else begin
      bad++;
      $error("[TB] FAIL %s sum: observed=%b expected=%b", tag, sum, exp_sum);
    end
    total++;
    assert (cout === exp_cout) else begin
      bad++;
      $error("[TB] FAIL %s cout: observed=%b expected=%b", tag, cout, exp_cout);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] a_v, input logic b_v, input logic cin_v);
    a   = a_v;
    b   = b_v;
    cin = cin_v;
    @(posedge clk);
    #1;
  endtask

  // One serial step k: the reference is the integer sum of the low k+1 bits.
  task automatic doStep(input string tag, input int k, input logic [W-1:0] a_v,
                        input logic b_v, input logic cin_v);
    int mask;
    int t;
    if (k == 0) begin
      a_acc  = 0;
      b_acc  = 0;
      c0_acc = int'(cin_v);
    end
    a_acc = a_acc | (int'(a_v[k]) << k);
    b_acc = b_acc | (int'(b_v) << k);
    applyStimulus(a_v, b_v, cin_v);
    mask = (1 << (k + 1)) - 1;
    t    = (a_acc & mask) + (b_acc & mask) + c0_acc;
    checkOutput($sformatf("%s.s%0d", tag, k), logic'((t >> k) & 1), logic'((t >> (k + 1)) & 1));
  endtask

  task automatic runWord(input string tag, input logic [W-1:0] a_v, input logic [W-1:0] b_w,
                         input logic c0, input logic c_other);
    for (int k = 0; k < W; k++) begin
      doStep(tag, k, a_v, b_w[k], (k == 0) ? c0 : c_other);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    a     = '0;
    b     = 1'b0;
    cin   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_hold", 1'b0, 1'b0);
    rst = 1'b0;

    runWord("ripple", 6'b000001, 6'b111111, 1'b0, 1'b0);
    runWord("cin_only", 6'b101010, 6'b000000, 1'b1, 1'b0);
    runWord("all_ones", 6'h3F, 6'b111111, 1'b1, 1'b1);
    runWord("cin_ignored", 6'h00, 6'b000000, 1'b0, 1'b1);

    // Asynchronous reset mid-cycle while outputs are high.
    doStep("pre_async", 0, 6'h3F, 1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset", 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("reset_across_edge", 1'b0, 1'b0);
    rst = 1'b0;

    // Reset during step 3 of the all-ones word, then a fresh word.
    for (int k = 0; k < 3; k++) begin
      doStep("abort_pre", k, 6'h3F, 1'b1, 1'b1);
    end
    a   = 6'h3F;
    b   = 1'b1;
    cin = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_reset", 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    runWord("after_abort", 6'h00, 6'b000000, 1'b1, 1'b0);

    // Random words, with a re-randomized every step to exercise mid-word changes.
    for (int w = 0; w < 40; w++) begin
      logic c0;
      c0 = logic'($urandom_range(0, 1));
      for (int k = 0; k < W; k++) begin
        doStep($sformatf("rand%0d", w), k, W'($urandom), logic'($urandom_range(0, 1)),
               (k == 0) ? c0 : logic'($urandom_range(0, 1)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
